// File: rtl/coin_credit_unit.sv
// Coin credit unit: conditions raw coin lines, accumulates credit, and handles vend deduction and refunds.
// Optional COIN_INHIBIT_EN: coins arriving while the machine is READY are rejected instead of accumulated.
module coin_credit_unit #(
    parameter int PRICE           = 25,
    parameter int CREDIT_W        = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int VAL_A           = 5,
    parameter int VAL_B           = 10,
    parameter int VAL_C           = 25
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_a,
    input  logic                coin_b,
    input  logic                coin_c,
    input  logic                cancel,
    input  logic                vend_done,
    input  logic                refund_ack,
    output logic                C,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          state,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_val,
    output logic                coin_reject
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCUM  = 3'd1,
        S_READY  = 3'd2,
        S_VEND   = 3'd3,
        S_REFUND = 3'd4
    } state_t;

    localparam int                  CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int                  SUM_W      = CREDIT_W + 2;
    localparam logic [SUM_W-1:0]    CREDIT_MAX = {2'b00, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);

    logic [2:0]       raw_lines;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       stable;
    logic [2:0]       coin_ev;
    logic [CNT_W-1:0] db_cnt [3];

    logic [SUM_W-1:0] coin_sum;
    logic [SUM_W-1:0] credit_total;
    logic             any_ev;
    logic             overflow;

    state_t              cur_state;
    state_t              next_state;
    logic [CREDIT_W-1:0] next_credit;
    logic [CREDIT_W-1:0] next_rval;
    logic                next_rv;
    logic                next_reject;
    logic                vend_take;
    logic                cancel_take;
    logic                coin_ok;

    assign raw_lines = {coin_c, coin_b, coin_a};
    assign state     = cur_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_lines;
            sync2 <= sync1;
        end
    end

    // A line flips its qualified level after DEBOUNCE_CYCLES samples disagreeing with it; only low-to-high flips emit an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable  <= '0;
            coin_ev <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                coin_ev[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_cnt[i]  <= '0;
                    stable[i]  <= sync2[i];
                    coin_ev[i] <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Coins landing together form one batch: credited as a whole or rejected as a whole.
    always_comb begin
        coin_sum = '0;
        if (coin_ev[0]) coin_sum = coin_sum + SUM_W'(VAL_A);
        if (coin_ev[1]) coin_sum = coin_sum + SUM_W'(VAL_B);
        if (coin_ev[2]) coin_sum = coin_sum + SUM_W'(VAL_C);
        credit_total = {2'b00, credit} + coin_sum;
        any_ev       = |coin_ev;
        overflow     = credit_total > CREDIT_MAX;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state    <= S_IDLE;
            credit       <= '0;
            refund_valid <= 1'b0;
            refund_val   <= '0;
            C            <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            cur_state    <= next_state;
            credit       <= next_credit;
            refund_valid <= next_rv;
            refund_val   <= next_rval;
            C            <= (next_state == S_READY);
            coin_reject  <= next_reject;
        end
    end

    // The idle/accum/ready classification follows the registered credit, so it lags a credit change by one cycle.
    always_comb begin
        next_state  = cur_state;
        next_credit = credit;
        next_rv     = refund_valid;
        next_rval   = refund_val;
        vend_take   = 1'b0;
        cancel_take = 1'b0;
        coin_ok     = 1'b0;
        case (cur_state)
            S_IDLE, S_ACCUM, S_READY: begin
                vend_take   = (cur_state == S_READY) && vend_done;
                cancel_take = (cur_state != S_IDLE) && cancel && !vend_take;
                if (vend_take) begin
                    next_credit = credit - PRICE_C;
                    next_state  = S_VEND;
                end else if (cancel_take) begin
                    next_state = S_REFUND;
                    next_rv    = 1'b1;
                    next_rval  = credit;
                end else begin
`ifdef COIN_INHIBIT_EN
                    coin_ok = any_ev && !overflow && (cur_state != S_READY);
`else
                    coin_ok = any_ev && !overflow;
`endif
                    if (coin_ok) begin
                        next_credit = credit_total[CREDIT_W-1:0];
                    end
                    if (credit == '0) begin
                        next_state = S_IDLE;
                    end else if (credit < PRICE_C) begin
                        next_state = S_ACCUM;
                    end else begin
                        next_state = S_READY;
                    end
                end
            end
            S_VEND: begin
                if (credit != '0) begin
                    next_state = S_REFUND;
                    next_rv    = 1'b1;
                    next_rval  = credit;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_REFUND: begin
                if (refund_ack) begin
                    next_state  = S_IDLE;
                    next_credit = '0;
                    next_rv     = 1'b0;
                    next_rval   = '0;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        next_reject = any_ev && !coin_ok;
    end

endmodule

// File: tb/tb_coin_credit_unit.sv
// Self-checking bench for coin_credit_unit: a cycle-level reference model plus directed scenarios with literal checkpoints.
module tb_coin_credit_unit;

    localparam int          PRICE = 25;
    localparam int          N     = 4;
    localparam int          VAL [3] = '{5, 10, 25};
    localparam logic [31:0] MASK  = (32'd1 << N) - 32'd1;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_a;
    logic       coin_b;
    logic       coin_c;
    logic       cancel;
    logic       vend_done;
    logic       refund_ack;
    logic       C;
    logic [7:0] credit;
    logic [2:0] state;
    logic       refund_valid;
    logic [7:0] refund_val;
    logic       coin_reject;

    int checks = 0;
    int fails  = 0;

    int          m_credit;
    int          m_state;
    int          m_rval;
    int          m_rej_count = 0;
    bit          m_c;
    bit          m_rv;
    bit          m_rej;
    bit          m_ev   [3];
    bit          m_q    [3];
    logic [31:0] m_hist [3];

    coin_credit_unit #(
        .PRICE(PRICE), .CREDIT_W(8), .DEBOUNCE_CYCLES(N),
        .VAL_A(5), .VAL_B(10), .VAL_C(25)
    ) dut (
        .clk(clk), .reset(reset),
        .coin_a(coin_a), .coin_b(coin_b), .coin_c(coin_c),
        .cancel(cancel), .vend_done(vend_done), .refund_ack(refund_ack),
        .C(C), .credit(credit), .state(state),
        .refund_valid(refund_valid), .refund_val(refund_val), .coin_reject(coin_reject)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] coins, input logic can, input logic vd, input logic ack);
        {coin_c, coin_b, coin_a} = coins;
        cancel     = can;
        vend_done  = vd;
        refund_ack = ack;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic coinPulse(input int line);
        logic [2:0] v;
        v       = 3'b000;
        v[line] = 1'b1;
        applyStimulus(v, 1'b0, 1'b0, 1'b0);
        waitCycles(6);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        waitCycles(10);
    endtask

    // Reference model: a coin line qualifies when the last N synchronized samples (raw delayed two cycles) all disagree with its level.
    initial forever begin
        int          sum;
        int          nc;
        int          ns;
        int          nrval;
        bit          any;
        bit          ok;
        bit          vend_ok;
        bit          cancel_ok;
        bit          nrv;
        logic [2:0]  raw;
        logic [31:0] w;
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_credit = 0; m_state = 0; m_rval = 0;
            m_c = 0; m_rv = 0; m_rej = 0;
            for (int i = 0; i < 3; i++) begin
                m_ev[i] = 0; m_q[i] = 0; m_hist[i] = '0;
            end
        end else begin
            sum = 0;
            any = 0;
            for (int i = 0; i < 3; i++) begin
                if (m_ev[i]) begin
                    sum += VAL[i];
                    any = 1;
                end
            end
            ok = 0; nc = m_credit; ns = m_state; nrv = m_rv; nrval = m_rval;
            vend_ok   = (m_state == 2) && vend_done;
            cancel_ok = (m_state == 1 || m_state == 2) && cancel && !vend_ok;
            if (m_state <= 2) begin
                if (vend_ok) begin
                    nc = m_credit - PRICE;
                    ns = 3;
                end else if (cancel_ok) begin
                    ns = 4; nrv = 1; nrval = m_credit;
                end else begin
                    ok = any && (m_credit + sum <= 255);
`ifdef COIN_INHIBIT_EN
                    if (m_state == 2) ok = 0;
`endif
                    if (ok) nc = m_credit + sum;
                    ns = (m_credit == 0) ? 0 : (m_credit < PRICE) ? 1 : 2;
                end
            end else if (m_state == 3) begin
                if (m_credit > 0) begin
                    ns = 4; nrv = 1; nrval = m_credit;
                end else begin
                    ns = 0;
                end
            end else if (refund_ack) begin
                ns = 0; nc = 0; nrv = 0; nrval = 0;
            end
            m_rej = any && !ok;
            if (m_rej) m_rej_count++;
            m_credit = nc; m_state = ns; m_rv = nrv; m_rval = nrval;
            m_c = (ns == 2);
            raw = {coin_c, coin_b, coin_a};
            for (int i = 0; i < 3; i++) begin
                m_hist[i] = {m_hist[i][30:0], raw[i]};
                w = (m_hist[i] >> 2) & MASK;
                m_ev[i] = 0;
                if (!m_q[i] && w == MASK) begin
                    m_q[i]  = 1;
                    m_ev[i] = 1;
                end else if (m_q[i] && w == 0) begin
                    m_q[i] = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (reset === 1'b1) begin
            checkOutput("credit", credit, m_credit);
            checkOutput("state", state, m_state);
            checkOutput("C", C, m_c);
            checkOutput("refund_valid", refund_valid, m_rv);
            checkOutput("refund_val", refund_val, m_rval);
            checkOutput("coin_reject", coin_reject, m_rej);
        end
    end

    initial begin
        int rej0;
        reset = 1'b0;
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        waitCycles(2);
        #2;
        checkOutput("rst_credit", credit, 0);
        checkOutput("rst_state", state, 0);
        checkOutput("rst_C", C, 0);
        checkOutput("rst_refund_valid", refund_valid, 0);
        checkOutput("rst_refund_val", refund_val, 0);
        checkOutput("rst_coin_reject", coin_reject, 0);
        @(negedge clk);
        reset = 1'b1;
        waitCycles(2);
        checkOutput("post_rst_state", state, 0);

        // Short glitch on coin_b must not qualify.
        applyStimulus(3'b010, 1'b0, 1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        waitCycles(12);
        checkOutput("glitch_credit", credit, 0);

        applyStimulus(3'b010, 1'b0, 1'b0, 1'b0);
        waitCycles(6);
        checkOutput("b_before_latency", credit, 0);
        waitCycles(1);
        checkOutput("b_at_latency", credit, 10);
        waitCycles(3);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        waitCycles(10);
        checkOutput("b_state_accum", state, 1);

        // Asynchronous reset in the middle of accumulation.
        coinPulse(0);
        checkOutput("acc_credit15", credit, 15);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_credit", credit, 0);
        checkOutput("async_state", state, 0);
        checkOutput("async_C", C, 0);
        checkOutput("async_refund_valid", refund_valid, 0);
        waitCycles(2);
        reset = 1'b1;
        waitCycles(3);
        checkOutput("after_async_refund_valid", refund_valid, 0);
        checkOutput("after_async_credit", credit, 0);

        // Reach READY, add a coin while READY, then vend.
        coinPulse(2);
        checkOutput("c25_state", state, 2);
        checkOutput("c25_C", C, 1);
        rej0 = m_rej_count;
        coinPulse(0);
`ifdef COIN_INHIBIT_EN
        checkOutput("inhibit_credit", credit, 25);
        checkOutput("inhibit_reject", m_rej_count - rej0, 1);
`else
        checkOutput("ready_coin_credit", credit, 30);
        checkOutput("ready_coin_reject", m_rej_count - rej0, 0);
`endif
        applyStimulus(3'b000, 1'b0, 1'b1, 1'b0);
        waitCycles(1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("vend_state", state, 3);
        checkOutput("vend_C", C, 0);
`ifdef COIN_INHIBIT_EN
        checkOutput("vend_credit", credit, 0);
`else
        checkOutput("vend_credit", credit, 5);
        waitCycles(1);
        checkOutput("change_state", state, 4);
        checkOutput("change_valid", refund_valid, 1);
        checkOutput("change_val", refund_val, 5);
`endif
        waitCycles(3);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("ack_state", state, 0);
        checkOutput("ack_credit", credit, 0);
        checkOutput("ack_C", C, 0);
        checkOutput("ack_valid", refund_valid, 0);

        // Cancel refund held without ack; a coin during REFUND is rejected.
        coinPulse(0);
        coinPulse(1);
        checkOutput("cancel_pre_credit", credit, 15);
        applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(3'b001, 1'b0, 1'b0, 1'b0);
        checkOutput("cancel_state", state, 4);
        rej0 = m_rej_count;
        for (int i = 0; i < 5; i++) begin
            waitCycles(1);
            checkOutput("cancel_hold_valid", refund_valid, 1);
            checkOutput("cancel_hold_val", refund_val, 15);
        end
        waitCycles(1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("refund_coin_reject", m_rej_count - rej0, 1);
        checkOutput("refund_coin_credit", credit, 15);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("cancel_ack_state", state, 0);
        checkOutput("cancel_ack_credit", credit, 0);
        waitCycles(8);

        // Control inputs in IDLE are ignored.
        applyStimulus(3'b000, 1'b1, 1'b1, 1'b1);
        waitCycles(1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("idle_ignore_state", state, 0);
        checkOutput("idle_ignore_valid", refund_valid, 0);

        // Two lines in the same cycle, then vend and cancel together.
        applyStimulus(3'b101, 1'b0, 1'b0, 1'b0);
        waitCycles(6);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        waitCycles(10);
        checkOutput("batch_credit", credit, 30);
        checkOutput("batch_state", state, 2);
        applyStimulus(3'b000, 1'b1, 1'b1, 1'b0);
        waitCycles(1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("vend_wins_state", state, 3);
        checkOutput("vend_wins_credit", credit, 5);
        waitCycles(1);
        checkOutput("vend_wins_refund", refund_val, 5);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("vend_wins_idle", state, 0);

        // Coin event in the same cycle as an accepted vend.
        coinPulse(2);
        rej0 = m_rej_count;
        applyStimulus(3'b001, 1'b0, 1'b0, 1'b0);
        waitCycles(6);
        applyStimulus(3'b000, 1'b0, 1'b1, 1'b0);
        waitCycles(1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("vend_coin_state", state, 3);
        checkOutput("vend_coin_credit", credit, 0);
        checkOutput("vend_coin_reject", m_rej_count - rej0, 1);
        waitCycles(10);
        checkOutput("vend_coin_idle", state, 0);

`ifndef COIN_INHIBIT_EN
        // Overflow boundary around 2^CREDIT_W-1.
        for (int i = 0; i < 10; i++) coinPulse(2);
        checkOutput("credit250", credit, 250);
        rej0 = m_rej_count;
        coinPulse(1);
        checkOutput("overflow_credit", credit, 250);
        checkOutput("overflow_reject", m_rej_count - rej0, 1);
        coinPulse(0);
        checkOutput("max_credit", credit, 255);
        applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("max_refund", refund_val, 255);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("max_ack_credit", credit, 0);
`endif

        waitCycles(3);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
